// File: rtl/burst_shift_reg.sv
// burst_shift_reg: loadable multi-mode register with hold, load, shift,
// rotate, increment and decrement operations, plus a burst sequencer that
// repeats one latched operation a programmed number of times.
module burst_shift_reg #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             cout,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remCnt_q, remCnt_d;
  logic [2:0]       burstMode_q, burstMode_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sout_q, sout_d;
  logic             cout_q, cout_d;
  logic             opValid;
  logic [2:0]       opMode;

  // Sequencer state register: state, remaining burst count, latched mode, done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remCnt_q    <= '0;
      burstMode_q <= MODE_HOLD;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remCnt_q    <= remCnt_d;
      burstMode_q <= burstMode_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic: start beats en in IDLE, a zero-length burst only pulses done
  always_comb begin
    state_d     = state_q;
    remCnt_d    = remCnt_q;
    burstMode_d = burstMode_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cnt != '0) begin
            state_d     = RUN;
            remCnt_d    = cnt;
            burstMode_d = mode;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        remCnt_d = remCnt_q - CNT_W'(1);
        if (remCnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: busy while the burst runs, zero follows the register directly
  always_comb begin
    busy = (state_q == RUN);
    done = done_q;
    q    = data_q;
    sout = sout_q;
    cout = cout_q;
    zero = (data_q == '0);
  end

  // Pick which operation, if any, hits the register this edge
  always_comb begin
    opValid = 1'b0;
    opMode  = mode;
    if (state_q == RUN) begin
      opValid = 1'b1;
      opMode  = burstMode_q;
    end else begin
      opValid = en && !start;
      opMode  = mode;
    end
  end

  // Datapath next value; sout only moves on shift/rotate, cout only on inc/dec
  always_comb begin
    data_d = data_q;
    sout_d = sout_q;
    cout_d = cout_q;
    if (opValid) begin
      case (opMode)
        MODE_HOLD: data_d = data_q;
        MODE_LOAD: data_d = d;
        MODE_SHL: begin
          data_d = {data_q[WIDTH-2:0], sin};
          sout_d = data_q[WIDTH-1];
        end
        MODE_SHR: begin
          data_d = {sin, data_q[WIDTH-1:1]};
          sout_d = data_q[0];
        end
        MODE_ROL: begin
          data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
          sout_d = data_q[WIDTH-1];
        end
        MODE_ROR: begin
          data_d = {data_q[0], data_q[WIDTH-1:1]};
          sout_d = data_q[0];
        end
        MODE_INC: {cout_d, data_d} = {1'b0, data_q} + (WIDTH+1)'(1);
        MODE_DEC: {cout_d, data_d} = {1'b0, data_q} - (WIDTH+1)'(1);
        default:  data_d = data_q;
      endcase
    end
  end

  // Datapath register
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      sout_q <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      data_q <= data_d;
      sout_q <= sout_d;
      cout_q <= cout_d;
    end
  end

endmodule
